regbank_port_ctrl: RTL and testbench
====================================

// Module: regbank_port_ctrl
// PURPOSE
//  Initiator side of the register_bank port protocol (ri_a/ri_b/ri_d/rw/d in, a/b out).
//  Accepts operand-read and result-write requests from the datapath over valid/ready channels.
//  Buffers writes in a small FIFO drained onto the bank's single write port.
//  Returns both read operands one cycle after acceptance, with read-after-write hazard handling.
// PARAMETERS
//  DEPTH   4   write-buffer entries; power of 2, >= 2
//  REG_W   8   register data width (from regbank_pkg)
//  IDX_W   3   register index width (from regbank_pkg)
// PORTS
//  clk         in   1      system clock; all state updates on posedge
//  rst         in   1      synchronous, active-high reset
//  rd_valid    in   1      read request valid
//  rd_ready    out  1      read request accepted when rd_valid && rd_ready
//  rd_ia       in   IDX_W  operand A register index
//  rd_ib       in   IDX_W  operand B register index
//  rsp_valid   out  1      operand response valid
//  rsp_ready   in   1      response consumed when rsp_valid && rsp_ready
//  rsp_a       out  REG_W  operand A value
//  rsp_b       out  REG_W  operand B value
//  wr_valid    in   1      write request valid
//  wr_ready    out  1      write request accepted when wr_valid && wr_ready
//  wr_idx      in   IDX_W  destination register index
//  wr_data     in   REG_W  write data
//  drain_en    in   1      1 = FIFO head may be written to bank this cycle
//  wr_pending  out  log2(DEPTH)+1  current FIFO occupancy
//  bank_ri_a   out  IDX_W  to register_bank ri_a (= rd_ia, combinational)
//  bank_ri_b   out  IDX_W  to register_bank ri_b (= rd_ib, combinational)
//  bank_ri_d   out  IDX_W  to register_bank ri_d (FIFO head index)
//  bank_rw     out  1      to register_bank rw (= drain_en && !empty)
//  bank_d      out  REG_W  to register_bank d (FIFO head data)
//  bank_a      in   REG_W  from register_bank a (combinational read)
//  bank_b      in   REG_W  from register_bank b (combinational read)
// BEHAVIOUR
//  - Reset: rsp_valid=0, rsp_a=rsp_b=0, FIFO empty, wr_pending=0, bank_rw=0; pending writes discarded (reset mid-drain loses them).
//  - Write path: push on wr_valid&&wr_ready; wr_ready = !full (a same-cycle pop does NOT free a slot for a push when full).
//  - Drain: when bank_rw=1, bank writes head at posedge and head pops same edge; max one write/cycle.
//  - Simultaneous push and pop on non-full FIFO: occupancy unchanged; pointers wrap mod DEPTH.
//  - Read path: rd_ready = (!rsp_valid || rsp_ready) && !stall; on accept, rsp_a/rsp_b register next edge, rsp_valid=1.
//  - Latency: request accepted cycle N -> rsp_valid at N+1. rsp_* held stable while rsp_valid && !rsp_ready.
//  - Ordering: a write accepted in the same cycle as a read is ordered AFTER that read (read sees old value).
//  - Hazard: "match" = any valid FIFO entry (head included, even while being drained) with idx == rd_ia (resp. rd_ib).
//  - rd_ia == rd_ib permitted; both operands resolved identically.
// CONFIGURATION
//  - REGBANK_BYPASS_EN defined: stall=0; on match, operand takes data of the YOUNGEST matching entry, else bank_a/bank_b.
//  - Undefined: stall = match on A or B; read waits until matching entries drain. drain_en held 0 with a match
//    deadlocks the read by design; the datapath must not do that.
// STRUCTURE
//  - regbank_pkg: REG_W=8, IDX_W=3, NREGS=8, write-entry struct {idx, data}.
//  - Sub-module regbank_wr_fifo: DEPTH-entry FIFO with head outputs and per-entry valid/idx/data exposed for match logic.
//  - Top: match/priority logic, response register, handshakes.
// TESTING
//  - Reset, then write r3<-0x5A with drain_en=1 -> bank_rw=1, bank_ri_d=3, bank_d=0x5A one cycle; later read (3,3) -> rsp_a=rsp_b=0x5A.
//  - drain_en=0, push 4 writes r0..r3 <- 0x10..0x13 -> wr_pending=4, wr_ready=0; 5th write not accepted; drain_en=1 -> 4 consecutive bank writes in order.
//  - drain_en=0, writes r2<-0x11 then r2<-0x22, read (2,5): BYPASS_EN -> rsp_a=0x22, rsp_b=bank r5 at N+1; no BYPASS_EN -> rd_ready=0 until both drained, then rsp_a=0x22.
//  - Same-cycle read r1 and write r1<-0x77 (r1 held 0x01) -> rsp_a=0x01; next read r1 -> 0x77.
//  - rsp_ready=0 for 3 cycles with rsp_valid=1 -> rd_ready=0, rsp_a/rsp_b stable; rsp_ready=1 -> next read accepted same cycle.
//  - rst asserted with 3 pending writes -> next cycle wr_pending=0, rsp_valid=0, bank_rw=0; bank keeps pre-reset contents.

Source files
------------

// File: rtl/regbank_pkg.sv
// Shared types and sizes for the register_bank initiator port.
package regbank_pkg;

  localparam int REG_W = 8;
  localparam int IDX_W = 3;
  localparam int NREGS = 8;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [REG_W-1:0] data;
  } wr_entry_t;

  function automatic logic idx_hit(input logic vld, input logic [IDX_W-1:0] ent_idx,
                                   input logic [IDX_W-1:0] rd_idx);
    return vld && (ent_idx == rd_idx);
  endfunction

endpackage

// File: rtl/regbank_wr_fifo.sv
// Write-buffer FIFO; entries are presented oldest-first so the match logic
// can pick the youngest hit by scanning upward.
module regbank_wr_fifo
  import regbank_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  wr_entry_t                 push_entry,
  input  logic                      pop,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count,
  output logic [DEPTH-1:0]          ent_valid,
  output wr_entry_t [DEPTH-1:0]     ent
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wr_entry_t        mem_r [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] cnt_r;
  logic             push_s;
  logic             pop_s;

  assign full   = (cnt_r == CNT_W'(DEPTH));
  assign empty  = (cnt_r == {CNT_W{1'b0}});
  assign count  = cnt_r;
  // a pop in the same cycle never frees a slot for a push when full
  assign push_s = push && !full;
  assign pop_s  = pop && !empty;

  // Pointer and occupancy state
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + 1'b1;
        2'b01:   cnt_r <= cnt_r - 1'b1;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Entry storage
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= push_entry;
    end
  end

  // Age-ordered view: slot 0 is the head
  always_comb begin
    ent       = '0;
    ent_valid = '0;
    for (int k = 0; k < DEPTH; k++) begin
      ent[k]       = mem_r[rd_ptr_r + PTR_W'(k)];
      ent_valid[k] = (CNT_W'(k) < cnt_r);
    end
  end

endmodule

// File: rtl/regbank_port_ctrl.sv
// Initiator side of the register_bank port: buffered writes, registered operand reads.
// Build option REGBANK_BYPASS_EN: forward buffered write data instead of stalling reads.
module regbank_port_ctrl
  import regbank_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_valid,
  output logic                   rd_ready,
  input  logic [IDX_W-1:0]       rd_ia,
  input  logic [IDX_W-1:0]       rd_ib,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [REG_W-1:0]       rsp_a,
  output logic [REG_W-1:0]       rsp_b,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [IDX_W-1:0]       wr_idx,
  input  logic [REG_W-1:0]       wr_data,
  input  logic                   drain_en,
  output logic [$clog2(DEPTH):0] wr_pending,
  output logic [IDX_W-1:0]       bank_ri_a,
  output logic [IDX_W-1:0]       bank_ri_b,
  output logic [IDX_W-1:0]       bank_ri_d,
  output logic                   bank_rw,
  output logic [REG_W-1:0]       bank_d,
  input  logic [REG_W-1:0]       bank_a,
  input  logic [REG_W-1:0]       bank_b
);

  logic                  full_s;
  logic                  empty_s;
  logic [DEPTH-1:0]      ent_valid_s;
  wr_entry_t [DEPTH-1:0] ent_s;
  wr_entry_t             push_entry_s;
  logic                  match_a_s;
  logic                  match_b_s;
  logic [REG_W-1:0]      byp_a_s;
  logic [REG_W-1:0]      byp_b_s;
  logic                  stall_s;
  logic [REG_W-1:0]      opa_s;
  logic [REG_W-1:0]      opb_s;
  logic                  rd_accept_s;
  logic                  rsp_valid_r;
  logic [REG_W-1:0]      rsp_a_r;
  logic [REG_W-1:0]      rsp_b_r;

  assign push_entry_s = '{idx: wr_idx, data: wr_data};

  regbank_wr_fifo #(.DEPTH(DEPTH)) u_wr_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (wr_valid),
    .push_entry (push_entry_s),
    .pop        (drain_en),
    .full       (full_s),
    .empty      (empty_s),
    .count      (wr_pending),
    .ent_valid  (ent_valid_s),
    .ent        (ent_s)
  );

  assign wr_ready  = !full_s;
  assign bank_rw   = drain_en && !empty_s;
  assign bank_ri_d = ent_s[0].idx;
  assign bank_d    = ent_s[0].data;
  assign bank_ri_a = rd_ia;
  assign bank_ri_b = rd_ib;

  // Hazard scan over the current buffer; later (younger) hits override earlier ones.
  // A write pushed this cycle is not yet visible, which orders it after the read.
  always_comb begin
    match_a_s = 1'b0;
    match_b_s = 1'b0;
    byp_a_s   = {REG_W{1'b0}};
    byp_b_s   = {REG_W{1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      if (idx_hit(ent_valid_s[k], ent_s[k].idx, rd_ia)) begin
        match_a_s = 1'b1;
        byp_a_s   = ent_s[k].data;
      end else begin
        byp_a_s   = byp_a_s;
      end
      if (idx_hit(ent_valid_s[k], ent_s[k].idx, rd_ib)) begin
        match_b_s = 1'b1;
        byp_b_s   = ent_s[k].data;
      end else begin
        byp_b_s   = byp_b_s;
      end
    end
  end

  // Operand source and stall selection
  always_comb begin
`ifdef REGBANK_BYPASS_EN
    stall_s = 1'b0;
    opa_s   = match_a_s ? byp_a_s : bank_a;
    opb_s   = match_b_s ? byp_b_s : bank_b;
`else
    stall_s = match_a_s || match_b_s;
    opa_s   = bank_a;
    opb_s   = bank_b;
`endif
  end

`ifndef REGBANK_BYPASS_EN
  logic unused_byp_s;
  assign unused_byp_s = ^{byp_a_s, byp_b_s};
`endif

  assign rd_ready    = (!rsp_valid_r || rsp_ready) && !stall_s;
  assign rd_accept_s = rd_valid && rd_ready;

  // Response register; held while the consumer back-pressures
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_r <= 1'b0;
      rsp_a_r     <= {REG_W{1'b0}};
      rsp_b_r     <= {REG_W{1'b0}};
    end else if (rd_accept_s) begin
      rsp_valid_r <= 1'b1;
      rsp_a_r     <= opa_s;
      rsp_b_r     <= opb_s;
    end else if (rsp_ready) begin
      rsp_valid_r <= 1'b0;
    end else begin
      rsp_valid_r <= rsp_valid_r;
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_a     = rsp_a_r;
  assign rsp_b     = rsp_b_r;

endmodule

// File: tb/tb_regbank_port_ctrl.sv
// Directed bench for regbank_port_ctrl with a behavioural register_bank attached.
module tb_regbank_port_ctrl;

  logic       clk;
  logic       rst;
  logic       rd_valid;
  logic       rd_ready;
  logic [2:0] rd_ia;
  logic [2:0] rd_ib;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_a;
  logic [7:0] rsp_b;
  logic       wr_valid;
  logic       wr_ready;
  logic [2:0] wr_idx;
  logic [7:0] wr_data;
  logic       drain_en;
  logic [2:0] wr_pending;
  logic [2:0] bank_ri_a;
  logic [2:0] bank_ri_b;
  logic [2:0] bank_ri_d;
  logic       bank_rw;
  logic [7:0] bank_d;
  logic [7:0] bank_a;
  logic [7:0] bank_b;

  logic [7:0] bank_m [8];
  logic       bank_load;
  int         tests;
  int         fails;

  regbank_port_ctrl #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_ia      (rd_ia),
    .rd_ib      (rd_ib),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_a      (rsp_a),
    .rsp_b      (rsp_b),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_idx     (wr_idx),
    .wr_data    (wr_data),
    .drain_en   (drain_en),
    .wr_pending (wr_pending),
    .bank_ri_a  (bank_ri_a),
    .bank_ri_b  (bank_ri_b),
    .bank_ri_d  (bank_ri_d),
    .bank_rw    (bank_rw),
    .bank_d     (bank_d),
    .bank_a     (bank_a),
    .bank_b     (bank_b)
  );

  always #5 clk = ~clk;

  // register_bank: combinational reads, one write port; r[i] preloads to i
  always @(posedge clk) begin
    if (bank_load) begin
      for (int i = 0; i < 8; i++) bank_m[i] <= 8'(i);
    end else if (bank_rw) begin
      bank_m[bank_ri_d] <= bank_d;
    end
  end
  assign bank_a = bank_m[bank_ri_a];
  assign bank_b = bank_m[bank_ri_b];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("%s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0; fails = 0;
    clk = 1'b0; rst = 1'b1; bank_load = 1'b1;
    rd_valid = 1'b0; rd_ia = 3'd0; rd_ib = 3'd0; rsp_ready = 1'b1;
    wr_valid = 1'b0; wr_idx = 3'd0; wr_data = 8'h00; drain_en = 1'b0;
    step(); step();
    rst = 1'b0; bank_load = 1'b0;
    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_a", rsp_a, 0);
    check("rst_rsp_b", rsp_b, 0);
    check("rst_pending", wr_pending, 0);
    check("rst_bank_rw", bank_rw, 0);
    check("rst_wr_ready", wr_ready, 1);
    check("rst_rd_ready", rd_ready, 1);

    // single write r3 <- 5A, drained the next cycle
    wr_valid = 1'b1; wr_idx = 3'd3; wr_data = 8'h5A; drain_en = 1'b1;
    step();
    wr_valid = 1'b0;
    #1;
    check("w1_pending", wr_pending, 1);
    check("w1_bank_rw", bank_rw, 1);
    check("w1_ri_d", bank_ri_d, 3);
    check("w1_d", bank_d, 8'h5A);
    step();
    check("w1_drained", wr_pending, 0);
    check("w1_rw_low", bank_rw, 0);
    rd_valid = 1'b1; rd_ia = 3'd3; rd_ib = 3'd3;
    #1;
    check("r33_ready", rd_ready, 1);
    step();
    rd_valid = 1'b0;
    check("r33_valid", rsp_valid, 1);
    check("r33_a", rsp_a, 8'h5A);
    check("r33_b", rsp_b, 8'h5A);

    // same-cycle read r1 and write r1 <- 77: read sees the old value
    rd_valid = 1'b1; rd_ia = 3'd1; rd_ib = 3'd1;
    wr_valid = 1'b1; wr_idx = 3'd1; wr_data = 8'h77;
    #1;
    check("rw_rd_ready", rd_ready, 1);
    check("rw_wr_ready", wr_ready, 1);
    step();
    rd_valid = 1'b0; wr_valid = 1'b0;
    check("rw_old_a", rsp_a, 8'h01);
    check("rw_old_b", rsp_b, 8'h01);
    step();
    check("rw_drained", wr_pending, 0);
    rd_valid = 1'b1; rd_ia = 3'd1; rd_ib = 3'd0;
    step();
    rd_valid = 1'b0;
    check("rw_new_a", rsp_a, 8'h77);
    check("rw_new_b", rsp_b, 8'h00);
    step();

    // response back-pressure
    rsp_ready = 1'b0;
    rd_valid = 1'b1; rd_ia = 3'd2; rd_ib = 3'd3;
    #1;
    check("bp_first_ready", rd_ready, 1);
    step();
    rd_ia = 3'd4; rd_ib = 3'd5;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("bp_rd_ready", rd_ready, 0);
      check("bp_valid", rsp_valid, 1);
      check("bp_a_stable", rsp_a, 8'h02);
      check("bp_b_stable", rsp_b, 8'h5A);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_ready", rd_ready, 1);
    step();
    rd_valid = 1'b0;
    check("bp_next_valid", rsp_valid, 1);
    check("bp_next_a", rsp_a, 8'h04);
    check("bp_next_b", rsp_b, 8'h05);
    step();
    check("bp_idle_valid", rsp_valid, 0);

    // fill the buffer with drain disabled, then drain in order
    drain_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wr_valid = 1'b1; wr_idx = 3'(k); wr_data = 8'(8'h10 + k);
      step();
    end
    check("fill_pending", wr_pending, 4);
    wr_idx = 3'd4; wr_data = 8'h14;
    #1;
    check("fill_wr_ready", wr_ready, 0);
    step();
    check("fill_5th_rejected", wr_pending, 4);
    wr_valid = 1'b0; drain_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("drain_rw", bank_rw, 1);
      check("drain_ri_d", bank_ri_d, k);
      check("drain_d", bank_d, 8'h10 + k);
      step();
    end
    check("drain_empty", wr_pending, 0);
    check("drain_rw_low", bank_rw, 0);

    // read-after-write hazard on r2 with two buffered writes
    drain_en = 1'b0;
    wr_valid = 1'b1; wr_idx = 3'd2; wr_data = 8'h11;
    step();
    wr_data = 8'h22;
    step();
    wr_valid = 1'b0;
    rd_valid = 1'b1; rd_ia = 3'd2; rd_ib = 3'd5;
    #1;
`ifdef REGBANK_BYPASS_EN
    check("haz_ready", rd_ready, 1);
    step();
    rd_valid = 1'b0;
    check("haz_a_youngest", rsp_a, 8'h22);
    check("haz_b_bank", rsp_b, 8'h05);
    drain_en = 1'b1;
    step(); step();
    check("haz_drained", wr_pending, 0);
`else
    check("haz_stall", rd_ready, 0);
    step();
    check("haz_stall2", rd_ready, 0);
    check("haz_no_rsp", rsp_valid, 0);
    drain_en = 1'b1;
    #1;
    check("haz_head_draining", rd_ready, 0);
    step();
    check("haz_pending1", wr_pending, 1);
    check("haz_stall3", rd_ready, 0);
    step();
    check("haz_pending0", wr_pending, 0);
    check("haz_released", rd_ready, 1);
    step();
    rd_valid = 1'b0;
    check("haz_a", rsp_a, 8'h22);
    check("haz_b", rsp_b, 8'h05);
`endif
    drain_en = 1'b0;
    step();

    // reset with three pending writes and a live response
    wr_valid = 1'b1; wr_idx = 3'd5; wr_data = 8'hAA;
    step();
    wr_idx = 3'd6; wr_data = 8'hBB;
    step();
    wr_idx = 3'd7; wr_data = 8'hCC;
    rd_valid = 1'b1; rd_ia = 3'd0; rd_ib = 3'd1;
    step();
    wr_valid = 1'b0; rd_valid = 1'b0;
    check("pre_rst_pending", wr_pending, 3);
    check("pre_rst_valid", rsp_valid, 1);
    check("pre_rst_a", rsp_a, 8'h10);
    check("pre_rst_b", rsp_b, 8'h11);
    rst = 1'b1;
    step();
    rst = 1'b0; drain_en = 1'b1;
    #1;
    check("mid_rst_pending", wr_pending, 0);
    check("mid_rst_valid", rsp_valid, 0);
    check("mid_rst_a", rsp_a, 0);
    check("mid_rst_bank_rw", bank_rw, 0);
    check("mid_rst_bank_r5", bank_m[5], 8'h05);
    rd_valid = 1'b1; rd_ia = 3'd5; rd_ib = 3'd7;
    step();
    rd_valid = 1'b0;
    check("post_rst_a", rsp_a, 8'h05);
    check("post_rst_b", rsp_b, 8'h07);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
